uart_rx_cfg: RTL

Parametrised UART receiver that replaces the fixed 8N1 receiver in the SoC serial path. It supports a configurable frame: 5–9 data bits, none/even/odd parity, and 1 or 2 stop bits. The baud divisor is set at runtime, and parity and framing errors are reported per frame. It sits between the RX pad and the serial-port SFR logic, and delivers one word per frame with a single-cycle valid strobe.

---
 rtl/uart_rx_cfg_if.sv | 41 ++++
 rtl/uart_rx_cfg.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: bundles the serial input, the runtime configuration and
// the per-frame result of uart_rx_cfg. The master modport is the receiver
// side; the slave modport is the consumer (SFR logic) that also supplies the
// line, the enable and the divisor.
// Optional feature macro: UART_RX_BREAK_EN adds the o_break member.
interface uart_rx_cfg_if #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) ();
  logic              i_rx_serial;
  logic              i_en;
  logic [DIV_W-1:0]  i_clks_per_bit;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_parity_err;
  logic              o_frame_err;
  logic              o_busy;
`ifdef UART_RX_BREAK_EN
  logic              o_break;

  modport master (
    input  i_rx_serial, i_en, i_clks_per_bit,
    output o_valid, o_data, o_parity_err, o_frame_err, o_busy, o_break
  );

  modport slave (
    output i_rx_serial, i_en, i_clks_per_bit,
    input  o_valid, o_data, o_parity_err, o_frame_err, o_busy, o_break
  );
`else
  modport master (
    input  i_rx_serial, i_en, i_clks_per_bit,
    output o_valid, o_data, o_parity_err, o_frame_err, o_busy
  );

  modport slave (
    output i_rx_serial, i_en, i_clks_per_bit,
    input  o_valid, o_data, o_parity_err, o_frame_err, o_busy
  );
`endif
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5..9 data bits, none/even/odd
// parity, 1 or 2 stop bits) with a runtime baud divisor latched per frame.
// The line goes through a 2-flop synchronizer; a start bit is confirmed at
// its middle, every following bit is sampled once mid-bit, and the frame
// result is presented with a one-cycle o_valid strobe right after the last
// stop sample.
// Optional feature macro: UART_RX_BREAK_EN adds o_break (all-zero frame).
module uart_rx_cfg #(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  uart_rx_cfg_if.master rx_bus
);

  localparam logic [DIV_W-1:0] LP_MIN_DIV   = DIV_W'(4);
  localparam logic [DIV_W-1:0] LP_CNT_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] LP_CNT_ZERO  = {DIV_W{1'b0}};
  localparam logic [3:0]       LP_LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0]       LP_LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rx_meta;
  logic              r_rx_s;
  logic              r_armed;
  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  w_cnt_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  w_div_clamped;
  logic [DIV_W-1:0]  w_half;
  logic [DIV_W-1:0]  w_last_tick;
  logic [3:0]        r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_bit;
  logic              r_stop_err;
  logic              w_start_go;
  logic              w_sample;
  logic              w_frame_done;

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_parity_err;
  logic              r_frame_err;
  logic              r_busy;
`ifdef UART_RX_BREAK_EN
  logic              r_seen_one;
  logic              r_break;
`endif

  // Parity check of a received word against its parity bit.
  function automatic logic f_parity_err(input logic [DATA_W-1:0] data,
                                        input logic par_bit);
    logic w_odd;
    w_odd = (^data) ^ par_bit;
    if (PARITY == 1) begin
      return w_odd;
    end else if (PARITY == 2) begin
      return ~w_odd;
    end else begin
      return 1'b0;
    end
  endfunction

  // Divisors below 4 cannot place a mid-bit sample reliably, so clamp them.
  assign w_div_clamped = (rx_bus.i_clks_per_bit < LP_MIN_DIV) ? LP_MIN_DIV
                                                              : rx_bus.i_clks_per_bit;
  assign w_half        = (r_div - LP_CNT_ONE) >> 1'b1;
  assign w_last_tick   = r_div - LP_CNT_ONE;

  // Two-flop synchronizer for the asynchronous RX pad; idles high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx_bus.i_rx_serial;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Re-arm only from a high line seen while idle, so a stuck-low line or a
  // frame ending on a low stop bit cannot start another frame by itself.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_armed <= 1'b0;
    end else if (w_start_go) begin
      r_armed <= 1'b0;
    end else if ((r_state == ST_IDLE) && r_rx_s) begin
      r_armed <= 1'b1;
    end else begin
      r_armed <= r_armed;
    end
  end

  // FSM state and bit-timing counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= LP_CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter and sample-strobe decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_start_go   = 1'b0;
    w_sample     = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = LP_CNT_ZERO;
        if (!r_rx_s && r_armed && rx_bus.i_en) begin
          w_state_nxt = ST_START;
          w_start_go  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        // Confirm the start bit at its middle; a high line there was a glitch.
        if (r_cnt == w_half) begin
          w_cnt_nxt = LP_CNT_ZERO;
          if (!r_rx_s) begin
            w_state_nxt = ST_DATA;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + LP_CNT_ONE;
        end
      end
      ST_DATA, ST_PARITY, ST_STOP: begin
        if (r_cnt == w_last_tick) begin
          w_cnt_nxt = LP_CNT_ZERO;
          w_sample  = 1'b1;
          case (r_state)
            ST_DATA: begin
              if (r_bit_cnt == LP_LAST_DATA) begin
                w_state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
              end else begin
                w_state_nxt = ST_DATA;
              end
            end
            ST_PARITY: begin
              w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
              // Leave at mid-stop so the next start edge is never missed.
              if (r_bit_cnt == LP_LAST_STOP) begin
                w_state_nxt  = ST_IDLE;
                w_frame_done = 1'b1;
              end else begin
                w_state_nxt = ST_STOP;
              end
            end
            default: begin
              w_state_nxt = ST_IDLE;
            end
          endcase
        end else begin
          w_cnt_nxt = r_cnt + LP_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = LP_CNT_ZERO;
      end
    endcase
  end

  // Per-frame datapath: divisor latch, bit index, shift register, parity
  // bit and stop-bit error accumulation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div      <= LP_CNT_ZERO;
      r_bit_cnt  <= 4'd0;
      r_shift    <= {DATA_W{1'b0}};
      r_par_bit  <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      if (w_start_go) begin
        r_div <= w_div_clamped;
      end
      if (w_state_nxt != r_state) begin
        r_bit_cnt <= 4'd0;
      end else if (w_sample) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (w_sample && (r_state == ST_DATA)) begin
        r_shift <= {r_rx_s, r_shift[DATA_W-1:1]};
      end
      if (w_sample && (r_state == ST_PARITY)) begin
        r_par_bit <= r_rx_s;
      end
      if (w_start_go) begin
        r_stop_err <= 1'b0;
      end else if (w_sample && (r_state == ST_STOP) && !r_rx_s) begin
        r_stop_err <= 1'b1;
      end
    end
  end

`ifdef UART_RX_BREAK_EN
  // Track whether any sampled bit of the frame was high (break detection).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seen_one <= 1'b0;
    end else if (w_start_go) begin
      r_seen_one <= 1'b0;
    end else if (w_sample && r_rx_s) begin
      r_seen_one <= 1'b1;
    end else begin
      r_seen_one <= r_seen_one;
    end
  end
`endif

  // Registered outputs: strobe, busy, and the frame result held until the
  // next strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_data       <= {DATA_W{1'b0}};
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_BREAK_EN
      r_break      <= 1'b0;
`endif
    end else begin
      r_valid <= w_frame_done;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (w_frame_done) begin
        r_data       <= r_shift;
        r_parity_err <= f_parity_err(r_shift, r_par_bit);
        r_frame_err  <= r_stop_err | ~r_rx_s;
`ifdef UART_RX_BREAK_EN
        r_break      <= ~(r_seen_one | r_rx_s);
`endif
      end
    end
  end

  assign rx_bus.o_valid      = r_valid;
  assign rx_bus.o_busy       = r_busy;
  assign rx_bus.o_data       = r_data;
  assign rx_bus.o_parity_err = r_parity_err;
  assign rx_bus.o_frame_err  = r_frame_err;
`ifdef UART_RX_BREAK_EN
  assign rx_bus.o_break      = r_break;
`endif

endmodule
